// File: rtl/logic_stream_reducer.sv
// Stream reducer: folds a valid/ready packet of N-bit words with OR/AND/XOR/NOR
// and presents one result word, the saturating beat count and an overflow flag.
module logic_stream_reducer #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;
  typedef enum logic [1:0] {OpOr, OpAnd, OpXor, OpNor} op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [N-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               in_xfer;
  logic [N-1:0]       fold;

  assign in_ready = (state_q != StHold) & ~rst;
  assign in_xfer  = in_valid & in_ready;

  // NOR accumulates as OR; the inversion is applied only on the way out.
  always_comb begin
    fold = acc_q | in_data;
    case (op_q)
      OpAnd:   fold = acc_q & in_data;
      OpXor:   fold = acc_q ^ in_data;
      default: fold = acc_q | in_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_xfer) begin
          op_d    = op_e'(op);
          acc_d   = in_data;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? StHold : StAcc;
        end
      end
      StAcc: begin
        if (in_xfer) begin
          acc_d = fold;
          if (cnt_q == {CNT_W{1'b1}}) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = in_last ? StHold : StAcc;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpOr;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result fields are forced to zero outside HOLD so consumers never see stale data.
  always_comb begin
    out_valid = (state_q == StHold);
    out_data  = '0;
    out_count = '0;
    out_ovf   = 1'b0;
    if (out_valid) begin
      out_data  = (op_q == OpNor) ? ~acc_q : acc_q;
      out_count = cnt_q;
      out_ovf   = ovf_q;
    end
  end

endmodule

// File: tb/tb_logic_stream_reducer.sv
// Bench for logic_stream_reducer: instance a (CNT_W=8) and instance b (CNT_W=2),
// expected results queued at stimulus time and popped on each output transfer.
module tb_logic_stream_reducer;

  typedef struct {
    logic [7:0] data;
    logic [7:0] count;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
  logic [7:0] a_in_data, a_out_data, a_out_count;
  logic [1:0] a_op;
  logic       b_rst, b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_out_count;
  logic [1:0] b_op;

  exp_t qa[$];
  exp_t qb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  logic_stream_reducer #(.N(8), .CNT_W(8)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_last(a_in_last), .op(a_op), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_count(a_out_count),
    .out_ovf(a_out_ovf)
  );

  logic_stream_reducer #(.N(8), .CNT_W(2)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .op(b_op), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_count(b_out_count),
    .out_ovf(b_out_ovf)
  );

  // Scoreboard: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid && a_out_ready) begin
      n_total++;
      if (qa.size() == 0) begin
        $display("FAIL a_unexpected_output: got data=%h count=%0d ovf=%0d, expected none",
                 a_out_data, a_out_count, a_out_ovf);
      end else begin
        e = qa.pop_front();
        if ({a_out_data, a_out_count, a_out_ovf} !== {e.data, e.count, e.ovf})
          $display("FAIL a_result: got data=%h count=%0d ovf=%0d, expected data=%h count=%0d ovf=%0d",
                   a_out_data, a_out_count, a_out_ovf, e.data, e.count, e.ovf);
        else n_pass++;
      end
    end
    if (b_out_valid && b_out_ready) begin
      n_total++;
      if (qb.size() == 0) begin
        $display("FAIL b_unexpected_output: got data=%h count=%0d ovf=%0d, expected none",
                 b_out_data, b_out_count, b_out_ovf);
      end else begin
        e = qb.pop_front();
        if ({b_out_data, b_out_count, b_out_ovf} !== {e.data, e.count[1:0], e.ovf})
          $display("FAIL b_result: got data=%h count=%0d ovf=%0d, expected data=%h count=%0d ovf=%0d",
                   b_out_data, b_out_count, b_out_ovf, e.data, e.count[1:0], e.ovf);
        else n_pass++;
      end
    end
  end

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input bit sel, input logic [7:0] d, input logic last,
                           input logic [1:0] o);
    bit done = 1'b0;
    if (!sel) begin
      a_in_valid = 1'b1; a_in_data = d; a_in_last = last; a_op = o;
    end else begin
      b_in_valid = 1'b1; b_in_data = d; b_in_last = last; b_op = o;
    end
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (sel ? b_in_ready : a_in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL beat_accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    #1;
    if (!sel) a_in_valid = 1'b0;
    else b_in_valid = 1'b0;
  endtask

  // Waits until all queued results for an instance are drained and it is idle.
  task automatic drain(input bit sel);
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!sel && qa.size() == 0 && !a_out_valid) done = 1'b1;
      if (sel && qb.size() == 0 && !b_out_valid) done = 1'b1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL drain_timeout: results pending=%0d, expected 0",
               sel ? qb.size() : qa.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_op = 2'b00; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_op = 2'b00; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (a_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, expected 0", a_in_ready);
    else n_pass++;
    n_total++;
    if ({a_out_valid, a_out_data, a_out_count, a_out_ovf} !== 18'd0)
      $display("FAIL reset_outputs: got %h, expected 0",
               {a_out_valid, a_out_data, a_out_count, a_out_ovf});
    else n_pass++;
    @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
      $display("FAIL reset_release_ready: got a=%b b=%b, expected 1 1", a_in_ready, b_in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_or();
    qa.push_back('{data: 8'h5A, count: 8'd1, ovf: 1'b0});
    send_beat(1'b0, 8'h5A, 1'b1, 2'b00);
    @(negedge clk);
    n_total++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0)
      $display("FAIL single_latency: got out_valid=%b in_ready=%b, expected 1 0",
               a_out_valid, a_in_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 8'h00)
      $display("FAIL single_after: got out_valid=%b in_ready=%b data=%h, expected 0 1 00",
               a_out_valid, a_in_ready, a_out_data);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_and_gap();
    qa.push_back('{data: 8'h30, count: 8'd3, ovf: 1'b0});
    send_beat(1'b0, 8'hFF, 1'b0, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    send_beat(1'b0, 8'hF0, 1'b0, 2'b10);
    send_beat(1'b0, 8'h3C, 1'b1, 2'b00);
    drain(1'b0);
  endtask

  task automatic test_xor_nor();
    qa.push_back('{data: 8'h00, count: 8'd3, ovf: 1'b0});
    send_beat(1'b0, 8'h0F, 1'b0, 2'b10);
    send_beat(1'b0, 8'hF0, 1'b0, 2'b10);
    send_beat(1'b0, 8'hFF, 1'b1, 2'b10);
    drain(1'b0);
    qa.push_back('{data: 8'hFC, count: 8'd2, ovf: 1'b0});
    send_beat(1'b0, 8'h01, 1'b0, 2'b11);
    send_beat(1'b0, 8'h02, 1'b1, 2'b11);
    drain(1'b0);
  endtask

  task automatic test_backpressure();
    int bad_hold = 0;
    a_out_ready = 1'b0;
    qa.push_back('{data: 8'h33, count: 8'd2, ovf: 1'b0});
    send_beat(1'b0, 8'h11, 1'b0, 2'b00);
    send_beat(1'b0, 8'h22, 1'b1, 2'b01);
    qa.push_back('{data: 8'h99, count: 8'd1, ovf: 1'b0});
    a_in_valid = 1'b1; a_in_data = 8'h99; a_in_last = 1'b1; a_op = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (a_out_valid !== 1'b1 || a_out_data !== 8'h33 || a_in_ready !== 1'b0) bad_hold++;
    end
    n_total++;
    if (bad_hold != 0)
      $display("FAIL backpressure_hold: got %0d unstable cycles, expected 0", bad_hold);
    else n_pass++;
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (a_in_ready !== 1'b0 || a_out_data !== 8'h33)
      $display("FAIL backpressure_xfer_cycle: got in_ready=%b data=%h, expected 0 33",
               a_in_ready, a_out_data);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
      $display("FAIL backpressure_release: got in_ready=%b out_valid=%b, expected 1 0",
               a_in_ready, a_out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    drain(1'b0);
  endtask

  task automatic test_overflow();
    qb.push_back('{data: 8'h01, count: 8'd3, ovf: 1'b1});
    for (int k = 0; k < 5; k++) send_beat(1'b1, 8'h01, (k == 4), 2'b00);
    drain(1'b1);
    qb.push_back('{data: 8'h06, count: 8'd2, ovf: 1'b0});
    send_beat(1'b1, 8'h02, 1'b0, 2'b00);
    send_beat(1'b1, 8'h04, 1'b1, 2'b00);
    drain(1'b1);
  endtask

  task automatic test_rst_mid();
    send_beat(1'b0, 8'h10, 1'b0, 2'b00);
    send_beat(1'b0, 8'h20, 1'b0, 2'b00);
    a_rst = 1'b1;
    a_in_valid = 1'b1; a_in_data = 8'h44; a_in_last = 1'b1;
    @(negedge clk);
    n_total++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0)
      $display("FAIL rst_mid_during: got in_ready=%b out_valid=%b, expected 0 0",
               a_in_ready, a_out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
      $display("FAIL rst_mid_after: got out_valid=%b in_ready=%b, expected 0 1",
               a_out_valid, a_in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    qa.push_back('{data: 8'h81, count: 8'd1, ovf: 1'b0});
    send_beat(1'b0, 8'h81, 1'b1, 2'b00);
    drain(1'b0);
  endtask

  initial begin
    test_reset();
    test_single_or();
    test_and_gap();
    test_xor_nor();
    test_backpressure();
    test_overflow();
    test_rst_mid();
    repeat (3) @(posedge clk);
    n_total++;
    if (qa.size() != 0 || qb.size() != 0)
      $display("FAIL leftover_results: got a=%0d b=%0d pending, expected 0 0",
               qa.size(), qb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
